// File: rtl/pwm_ramp_ctrl.sv
// Four-channel PWM duty sequencer: ramps each channel's duty toward a written
// target, changing num only on period_start step events.
module pwm_ramp_ctrl #(
  parameter int unsigned DUTY_W = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  period_start,
  input  logic                  enable,
  input  logic [DIV_W-1:0]      ramp_div,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_ch,
  input  logic [DUTY_W-1:0]     cfg_target,
  input  logic [DUTY_W-1:0]     cfg_step,
  output logic [4*DUTY_W-1:0]   num,
  output logic [3:0]            busy,
  output logic [3:0]            done
);

  localparam int unsigned NCH = 4;

  typedef enum logic {IDLE, RAMP} state_t;

  state_t            state     [NCH];
  state_t            state_nxt [NCH];
  logic [DUTY_W-1:0] cur       [NCH];
  logic [DUTY_W-1:0] cur_nxt   [NCH];
  logic [DUTY_W-1:0] tgt       [NCH];
  logic [DUTY_W-1:0] stp       [NCH];
  logic [NCH-1:0]    done_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_cnt_nxt;
  logic              step_evt_c;
  logic              cfg_fire_c;

  assign cfg_fire_c = cfg_valid && cfg_ready;

  // One step toward the target, clamped so it never overshoots or wraps.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] c,
    input logic [DUTY_W-1:0] t,
    input logic [DUTY_W-1:0] s
  );
    logic [DUTY_W:0]   sum;
    logic [DUTY_W-1:0] gap;
    sum = {1'b0, c} + {1'b0, s};
    gap = c - t;
    if (s == '0 || c == t) begin
      return t;
    end
    if (c < t) begin
      return (sum >= {1'b0, t}) ? t : sum[DUTY_W-1:0];
    end
    return (gap <= s) ? t : DUTY_W'(c - s);
  endfunction

  // Ramp-rate divider; >= keeps a lowered ramp_div from stalling the count.
  always_comb begin
    step_evt_c  = 1'b0;
    div_cnt_nxt = div_cnt;
    if (period_start && enable) begin
      if (div_cnt >= ramp_div) begin
        step_evt_c  = 1'b1;
        div_cnt_nxt = '0;
      end else begin
        div_cnt_nxt = div_cnt + DIV_W'(1);
      end
    end
  end

  // Per-channel next state; a retarget onto the current duty exits quietly.
  always_comb begin
    done_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      state_nxt[i] = state[i];
      cur_nxt[i]   = cur[i];
      case (state[i])
        IDLE: begin
          if (tgt[i] != cur[i]) begin
            state_nxt[i] = RAMP;
          end
        end
        RAMP: begin
          if (tgt[i] == cur[i]) begin
            state_nxt[i] = IDLE;
          end else if (step_evt_c) begin
            cur_nxt[i] = step_toward(cur[i], tgt[i], stp[i]);
            if (cur_nxt[i] == tgt[i]) begin
              state_nxt[i] = IDLE;
              done_nxt[i]  = 1'b1;
            end
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready <= 1'b0;
      div_cnt   <= '0;
      done      <= '0;
      for (int i = 0; i < NCH; i++) begin
        state[i] <= IDLE;
        cur[i]   <= '0;
        tgt[i]   <= '0;
        stp[i]   <= '0;
      end
    end else begin
      cfg_ready <= 1'b1;
      div_cnt   <= div_cnt_nxt;
      done      <= done_nxt;
      for (int i = 0; i < NCH; i++) begin
        state[i] <= state_nxt[i];
        cur[i]   <= cur_nxt[i];
      end
      if (cfg_fire_c) begin
        tgt[cfg_ch] <= cfg_target;
        stp[cfg_ch] <= cfg_step;
      end
    end
  end

  // Outputs straight from flops.
  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign num[g*DUTY_W +: DUTY_W] = cur[g];
    assign busy[g]                 = (state[g] == RAMP);
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed self-checking bench for pwm_ramp_ctrl.
module tb_pwm_ramp_ctrl;

  localparam int unsigned DUTY_W = 8;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned PER    = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              period_start;
  logic              enable;
  logic [DIV_W-1:0]  ramp_div;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [DUTY_W-1:0] cfg_target;
  logic [DUTY_W-1:0] cfg_step;
  logic [31:0]       num;
  logic [3:0]        busy;
  logic [3:0]        done;

  int vectors = 0;
  int errors  = 0;

  pwm_ramp_ctrl #(.DUTY_W(DUTY_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .period_start(period_start), .enable(enable),
    .ramp_div(ramp_div), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_target(cfg_target), .cfg_step(cfg_step),
    .num(num), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] t, input logic [7:0] s);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_target = t; cfg_step = s;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_period();
    repeat (PER - 1) tick();
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_target = 8'd77; cfg_step = 8'd5;
    repeat (3) tick();
    vectors++;
    if (num !== 32'h0) begin errors++; $display("FAIL reset_num got=%h exp=%h", num, 32'h0); end
    vectors++;
    if (busy !== 4'h0 || done !== 4'h0) begin errors++; $display("FAIL reset_busy_done got=%b/%b exp=0000/0000", busy, done); end
    vectors++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", cfg_ready); end
    cfg_valid = 1'b0; rst = 1'b0;
    tick();
    vectors++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", cfg_ready); end
    repeat (2) tick();
    vectors++;
    if (busy !== 4'h0) begin errors++; $display("FAIL reset_no_capture busy got=%b exp=0000", busy); end
  endtask

  task automatic test_up_ramp();
    logic [7:0] exp_duty [4];
    exp_duty[0] = 8'd30; exp_duty[1] = 8'd60; exp_duty[2] = 8'd90; exp_duty[3] = 8'd100;
    ramp_div = 8'd0;
    cfg_write(2'd0, 8'd100, 8'd30);
    tick();
    vectors++;
    if (busy !== 4'b0001) begin errors++; $display("FAIL up_busy got=%b exp=0001", busy); end
    for (int i = 0; i < 4; i++) begin
      do_period();
      vectors++;
      if (num[7:0] !== exp_duty[i]) begin errors++; $display("FAIL up_duty[%0d] got=%0d exp=%0d", i, num[7:0], exp_duty[i]); end
      vectors++;
      if (done[0] !== (i == 3)) begin errors++; $display("FAIL up_done[%0d] got=%b exp=%b", i, done[0], (i == 3)); end
    end
    vectors++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL up_busy_fall got=%b exp=0", busy[0]); end
    tick();
    vectors++;
    if (done[0] !== 1'b0) begin errors++; $display("FAIL up_done_width got=%b exp=0", done[0]); end
  endtask

  task automatic test_down_ramp();
    logic [7:0] exp_duty [6];
    int dones;
    exp_duty[0] = 8'd250; exp_duty[1] = 8'd250; exp_duty[2] = 8'd190;
    exp_duty[3] = 8'd190; exp_duty[4] = 8'd190; exp_duty[5] = 8'd150;
    cfg_write(2'd2, 8'd250, 8'd0);
    tick();
    do_period();
    vectors++;
    if (num[23:16] !== 8'd250) begin errors++; $display("FAIL down_preload got=%0d exp=250", num[23:16]); end
    ramp_div = 8'd2;
    cfg_write(2'd2, 8'd150, 8'd60);
    tick();
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      do_period();
      if (done[2]) dones++;
      vectors++;
      if (num[23:16] !== exp_duty[i]) begin errors++; $display("FAIL down_duty[%0d] got=%0d exp=%0d", i, num[23:16], exp_duty[i]); end
    end
    vectors++;
    if (dones != 1 || done[2] !== 1'b1) begin errors++; $display("FAIL down_done got=%0d/%b exp=1/1", dones, done[2]); end
  endtask

  task automatic test_parallel();
    ramp_div = 8'd0;
    cfg_write(2'd1, 8'd10, 8'd0);
    cfg_write(2'd3, 8'd255, 8'd200);
    tick();
    do_period();
    vectors++;
    if (num !== {8'd200, 8'd150, 8'd10, 8'd100}) begin errors++; $display("FAIL par_num1 got=%h exp=%h", num, {8'd200, 8'd150, 8'd10, 8'd100}); end
    vectors++;
    if (done !== 4'b0010) begin errors++; $display("FAIL par_done1 got=%b exp=0010", done); end
    do_period();
    vectors++;
    if (num !== {8'd255, 8'd150, 8'd10, 8'd100}) begin errors++; $display("FAIL par_num2 got=%h exp=%h", num, {8'd255, 8'd150, 8'd10, 8'd100}); end
    vectors++;
    if (done !== 4'b1000) begin errors++; $display("FAIL par_done2 got=%b exp=1000", done); end
  endtask

  task automatic test_retarget();
    cfg_write(2'd0, 8'd0, 8'd0);
    tick();
    do_period();
    vectors++;
    if (num[7:0] !== 8'd0) begin errors++; $display("FAIL rt_zero got=%0d exp=0", num[7:0]); end
    cfg_write(2'd0, 8'd200, 8'd50);
    tick();
    do_period();
    do_period();
    vectors++;
    if (num[7:0] !== 8'd100 || busy[0] !== 1'b1) begin errors++; $display("FAIL rt_mid got=%0d/%b exp=100/1", num[7:0], busy[0]); end
    cfg_write(2'd0, 8'd100, 8'd50);
    tick();
    vectors++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin errors++; $display("FAIL rt_abort got=%b/%b exp=0/0", busy[0], done[0]); end
    do_period();
    vectors++;
    if (num[7:0] !== 8'd100 || done[0] !== 1'b0) begin errors++; $display("FAIL rt_hold got=%0d/%b exp=100/0", num[7:0], done[0]); end
    cfg_write(2'd0, 8'd200, 8'd50);
    tick();
    do_period();
    vectors++;
    if (num[7:0] !== 8'd150) begin errors++; $display("FAIL rt_resume got=%0d exp=150", num[7:0]); end
    // write and step event together: step must use old target 200 / step 50
    repeat (PER - 1) tick();
    period_start = 1'b1;
    cfg_write(2'd0, 8'd0, 8'd10);
    period_start = 1'b0;
    vectors++;
    if (num[7:0] !== 8'd200 || done[0] !== 1'b1) begin errors++; $display("FAIL rt_same_cycle got=%0d/%b exp=200/1", num[7:0], done[0]); end
    tick();
    vectors++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL rt_reeval busy got=%b exp=1", busy[0]); end
    do_period();
    vectors++;
    if (num[7:0] !== 8'd190) begin errors++; $display("FAIL rt_new_step got=%0d exp=190", num[7:0]); end
  endtask

  task automatic test_freeze_reset();
    ramp_div = 8'd2;
    do_period();
    vectors++;
    if (num[7:0] !== 8'd190 || dut.div_cnt !== 8'd1) begin errors++; $display("FAIL frz_pre got=%0d/%0d exp=190/1", num[7:0], dut.div_cnt); end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_period();
      vectors++;
      if (num[7:0] !== 8'd190 || dut.div_cnt !== 8'd1) begin errors++; $display("FAIL frz_hold[%0d] got=%0d/%0d exp=190/1", i, num[7:0], dut.div_cnt); end
    end
    enable = 1'b1;
    do_period();
    do_period();
    vectors++;
    if (num[7:0] !== 8'd180) begin errors++; $display("FAIL frz_resume got=%0d exp=180", num[7:0]); end
    do_period();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (num !== 32'h0 || busy !== 4'h0 || dut.div_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset got=%h/%b/%0d exp=0/0000/0", num, busy, dut.div_cnt); end
    vectors++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got=%b exp=0", cfg_ready); end
    repeat (2) tick();
    vectors++;
    if (busy !== 4'h0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL post_reset got=%b/%b exp=0000/1", busy, cfg_ready); end
  endtask

  initial begin
    rst = 1'b1; period_start = 1'b0; enable = 1'b1; ramp_div = '0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_target = '0; cfg_step = '0;
    test_reset();
    test_up_ramp();
    test_down_ramp();
    test_parallel();
    test_retarget();
    test_freeze_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
